// File: rtl/dmem_wait_responder_if.sv
// dmem_wait_responder_if
// Memory-stage bus between the pipeline (master) and the data-memory
// responder (slave).
//   MemReadM/MemWriteM : load/store request, held while StallMem=1
//   DataAdrM           : byte address
//   WriteDataM         : store data
//   ReadDataM          : registered load data
//   StallMem           : pipeline freeze while an access is outstanding
//   WatchHit/WatchData/WatchCount : store-watch status (zero when unbuilt)
interface dmem_wait_responder_if;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] DataAdrM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMem;
  logic        WatchHit;
  logic [31:0] WatchData;
  logic [15:0] WatchCount;

  modport master (
    output MemReadM, MemWriteM, DataAdrM, WriteDataM,
    input  ReadDataM, StallMem, WatchHit, WatchData, WatchCount
  );

  modport slave (
    input  MemReadM, MemWriteM, DataAdrM, WriteDataM,
    output ReadDataM, StallMem, WatchHit, WatchData, WatchCount
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder
// Word-addressed data RAM answering Memory-stage loads/stores after a fixed
// number of wait states, stalling the pipeline while an access is pending.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dmem_wait_responder_if.slave (request in, data/stall/watch out)
// Optional store-watch unit is built when DMEM_STORE_WATCH_EN is defined;
// otherwise the watch outputs are tied to zero.
module dmem_wait_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] WATCH_ADDR  = 32'd100,
  parameter logic [31:0] WATCH_VALUE = 32'd7
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_wait_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               commit;
  logic               stall;

  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic               wr_q;
  logic [31:0]        rdata_q;

  logic [31:0]        mem [DEPTH_WORDS];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, wait counter and stall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.MemReadM | bus.MemWriteM) begin
          accept  = 1'b1;
          stall   = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          commit  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A held request must not re-assert the stall while reset is applied.
    if (reset) stall = 1'b0;
  end

  assign bus.StallMem = stall;

  // Request capture; a simultaneous read+write is taken as a write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      idx_q   <= bus.DataAdrM[IDX_W+1:2];
      wdata_q <= bus.WriteDataM;
      wr_q    <= bus.MemWriteM;
    end
  end

  // Load data, held until the next read completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (commit && !wr_q) begin
      rdata_q <= mem[idx_q];
    end
  end

  assign bus.ReadDataM = rdata_q;

  // RAM array; contents survive reset, and commit cannot fire from IDLE
  always_ff @(posedge clk) begin
    if (commit && wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

`ifdef DMEM_STORE_WATCH_EN
  logic        watch_match_q;
  logic        hit_q;
  logic [31:0] wdat_q;
  logic [15:0] wcnt_q;

  // Full byte-address compare captured with the request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      watch_match_q <= 1'b0;
    end else if (accept) begin
      watch_match_q <= (bus.DataAdrM == WATCH_ADDR);
    end
  end

  // Watch status updates on the same edge as the RAM write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q  <= 1'b0;
      wdat_q <= '0;
      wcnt_q <= '0;
    end else if (commit && wr_q) begin
      if (wcnt_q != 16'hFFFF) wcnt_q <= wcnt_q + 16'd1;
      if (watch_match_q) begin
        wdat_q <= wdata_q;
        if (wdata_q == WATCH_VALUE) hit_q <= 1'b1;
      end
    end
  end

  assign bus.WatchHit   = hit_q;
  assign bus.WatchData  = wdat_q;
  assign bus.WatchCount = wcnt_q;
`else
  // Address bits outside the word index and watch settings have no sink here.
  logic        unused_adr;
  logic [63:0] unused_watch_cfg;
  assign unused_adr       = ^{bus.DataAdrM[31:IDX_W+2], bus.DataAdrM[1:0]};
  assign unused_watch_cfg = {WATCH_ADDR, WATCH_VALUE};

  assign bus.WatchHit   = 1'b0;
  assign bus.WatchData  = '0;
  assign bus.WatchCount = '0;
`endif

endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb_dmem_wait_responder
// Self-checking bench: directed vector table, hand-written reset/watch
// sequences and a randomized run against a word-array reference model.
module tb_dmem_wait_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WAITC = 2;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  dmem_wait_responder_if bus();

  dmem_wait_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAITC),
    .WATCH_ADDR  (32'd100),
    .WATCH_VALUE (32'd7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RAM words plus observable output values
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  logic        m_hit;
  logic [31:0] m_wdata;
  logic [15:0] m_cnt;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rdata = '0;
    m_hit   = 1'b0;
    m_wdata = '0;
    m_cnt   = '0;
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] adr,
                        input logic [31:0] wd, input string nm, output logic [31:0] got);
    int  stall_n;
    bit  done;
    int unsigned idx;
    bus.MemReadM   = rd;
    bus.MemWriteM  = wr;
    bus.DataAdrM   = adr;
    bus.WriteDataM = wd;
    stall_n = 0;
    done    = 1'b0;
    for (int i = 0; i < 32 && !done; i++) begin
      @(negedge clk);
      if (bus.StallMem) stall_n++;
      else done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: stall still high after %0d cycles, want low after %0d", nm, stall_n, WAITC + 1);
    end
    idx = (adr / 4) % DEPTH;
    if (wr) begin
      m_mem[idx] = wd;
`ifdef DMEM_STORE_WATCH_EN
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (adr == 32'd100) begin
        m_wdata = wd;
        if (wd == 32'd7) m_hit = 1'b1;
      end
`endif
    end else begin
      m_rdata = m_mem[idx];
    end
    check({nm, "_stall_cycles"}, 32'(stall_n), 32'(WAITC + 1));
    check({nm, "_rdata"}, bus.ReadDataM, m_rdata);
    check({nm, "_watch_hit"}, 32'(bus.WatchHit), 32'(m_hit));
    check({nm, "_watch_data"}, bus.WatchData, m_wdata);
    check({nm, "_watch_count"}, 32'(bus.WatchCount), 32'(m_cnt));
    got = bus.ReadDataM;
    @(posedge clk);
    #1;
    bus.MemReadM  = 1'b0;
    bus.MemWriteM = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] prior;
    logic        exp_hit;
    logic [31:0] exp_wdat;
    logic [15:0] exp_cnt;

    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.MemReadM   = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.DataAdrM   = '0;
    bus.WriteDataM = '0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_rdata", bus.ReadDataM, 32'h0);
    check("reset_stall", 32'(bus.StallMem), 32'h0);
    check("reset_watch_hit", 32'(bus.WatchHit), 32'h0);
    check("reset_watch_data", bus.WatchData, 32'h0);
    check("reset_watch_count", 32'(bus.WatchCount), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Give every word a defined value
    for (int i = 0; i < int'(DEPTH); i++) begin
      access(1'b0, 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), "init", got);
    end

    // Directed vectors
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_002A, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0000_002A};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0104, 32'h0000_0055, 32'h0000_002A};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0055};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0030, 32'h0000_0011, 32'h0000_0055};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'h0000_0011};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0099, 32'h0000_0011};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h0000_0099};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_000B, 32'h0000_0000, 32'h0000_0099};
    vecs[9] = '{1'b1, 1'b0, 32'hFFFF_FF08, 32'h0000_0000, 32'h0000_0099};
    for (int v = 0; v < 10; v++) begin
      access(vecs[v].rd, vecs[v].wr, vecs[v].adr, vecs[v].wd, $sformatf("vec%0d", v), got);
      check($sformatf("vec%0d_table", v), got, vecs[v].exp_rdata);
    end

    // Reset during the WAIT cycle of a write
    prior = m_mem[4];
    bus.MemWriteM  = 1'b1;
    bus.DataAdrM   = 32'h0000_0010;
    bus.WriteDataM = 32'h0000_00FF;
    @(negedge clk);
    check("rst_mid_accept_stall", 32'(bus.StallMem), 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_mid_stall", 32'(bus.StallMem), 32'h0);
    check("rst_mid_rdata", bus.ReadDataM, 32'h0);
    bus.MemWriteM = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, "rst_mid_read", got);
    check("rst_mid_prior", got, prior);

    // Store-watch sequence from a fresh reset
    reset_pulse();
`ifdef DMEM_STORE_WATCH_EN
    exp_hit = 1'b1; exp_wdat = 32'd7; exp_cnt = 16'd3;
`else
    exp_hit = 1'b0; exp_wdat = 32'd0; exp_cnt = 16'd0;
`endif
    access(1'b0, 1'b1, 32'd100, 32'd5, "watch_st1", got);
    check("watch_st1_hit", 32'(bus.WatchHit), 32'h0);
    access(1'b0, 1'b1, 32'd100, 32'd7, "watch_st2", got);
    check("watch_st2_hit", 32'(bus.WatchHit), 32'(exp_hit));
    access(1'b0, 1'b1, 32'd96, 32'd3, "watch_st3", got);
    check("watch_final_hit", 32'(bus.WatchHit), 32'(exp_hit));
    check("watch_final_data", bus.WatchData, exp_wdat);
    check("watch_final_count", 32'(bus.WatchCount), 32'(exp_cnt));

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      int unsigned kind;
      logic [31:0] adr;
      logic [31:0] wd;
      kind = $urandom_range(0, 2);
      adr  = ($urandom_range(0, 7) == 0) ? 32'd100 : $urandom;
      wd   = ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom;
      access(kind != 1, kind != 0, adr, wd, $sformatf("rnd%0d", n), got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
